// File: rtl/sync_up_counter_pkg.sv
// Shared constants and helpers for sync_up_counter.
// Default width, default terminal value and load clamping.
package sync_up_counter_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  function automatic int unsigned def_max(
    input int unsigned w
  );
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  function automatic int unsigned clamp(
    input int unsigned v,
    input int unsigned m
  );
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/sync_up_counter_next.sv
// Next-state logic for sync_up_counter: next count, wrap, tc.
// Purely combinational; priority clear > load > enable > hold.
module sync_up_counter_next
  import sync_up_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MAX_VAL = def_max(WIDTH)
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_d_o,
  output logic             wrap_d_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic at_max;

  assign at_max = (count_i == MAXV);
  assign tc_o   = enable_i & at_max;

  always_comb begin
    count_d_o = count_i;
    wrap_d_o  = 1'b0;
    if (clear_i) begin
      count_d_o = '0;
    end else if (load_i) begin
      count_d_o = load_value_i;
    end else if (enable_i) begin
      if (at_max) begin
        count_d_o = '0;
        wrap_d_o  = 1'b1;
      end else begin
        count_d_o = count_i + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sync_up_counter.sv
// Up-counter with enable, clear, wrap pulse and terminal count.
// Parallel load present only with SYNC_UP_COUNTER_LOAD_EN.
module sync_up_counter
  import sync_up_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MAX_VAL = def_max(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
`ifdef SYNC_UP_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tc_n;
  logic             ld;
  logic [WIDTH-1:0] ldv;

`ifdef SYNC_UP_COUNTER_LOAD_EN
  assign ld  = load;
  assign ldv = WIDTH'(clamp(32'(load_value), MAX_VAL));
`else
  assign ld  = 1'b0;
  assign ldv = '0;
`endif

  sync_up_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count_i      (count_q),
    .enable_i     (enable),
    .clear_i      (clear),
    .load_i       (ld),
    .load_value_i (ldv),
    .count_d_o    (count_d),
    .wrap_d_o     (wrap_d),
    .tc_o         (tc_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // tc is masked while in reset even if MAX_VAL is 0
  assign tc    = tc_n & reset;
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_sync_up_counter.sv
// Directed bench for sync_up_counter: default and MAX_VAL=9.
// Load tests build only with SYNC_UP_COUNTER_LOAD_EN.
module tb_sync_up_counter;

  logic       clk;
  logic       reset;
  logic       en, clr, ld;
  logic [3:0] lv;
  logic [3:0] cnt;
  logic       tc, wrap;
  logic       en9, clr9, ld9;
  logic [3:0] lv9;
  logic [3:0] cnt9;
  logic       tc9, wrap9;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_up_counter u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (en),
    .clear      (clr),
`ifdef SYNC_UP_COUNTER_LOAD_EN
    .load       (ld),
    .load_value (lv),
`endif
    .count      (cnt),
    .tc         (tc),
    .wrap       (wrap)
  );

  sync_up_counter #(
    .WIDTH   (4),
    .MAX_VAL (9)
  ) u_dut9 (
    .clk        (clk),
    .reset      (reset),
    .enable     (en9),
    .clear      (clr9),
`ifdef SYNC_UP_COUNTER_LOAD_EN
    .load       (ld9),
    .load_value (lv9),
`endif
    .count      (cnt9),
    .tc         (tc9),
    .wrap       (wrap9)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    en = 0; clr = 0; ld = 0;
    en9 = 0; clr9 = 0; ld9 = 0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #4;
    n_tests++;
    if (cnt !== 4'd0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state cnt=%0d wrap=%b want 0 0", cnt, wrap);
    end
    n_tests++;
    if (tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tc tc=%b want 0", tc);
    end
    #8;
    reset = 1'b1;
    step();
    n_tests++;
    if (cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL post_release cnt=%0d want 0", cnt);
    end
  endtask

  task automatic test_count();
    en = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_tests++;
      if (cnt !== 4'(i)) begin
        n_fail++;
        $display("FAIL count_seq cnt=%0d want %0d", cnt, i);
      end
    end
    en = 0;
    step();
    step();
    n_tests++;
    if (cnt !== 4'd10 || wrap !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL hold cnt=%0d wrap=%b tc=%b want 10 0 0",
               cnt, wrap, tc);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset cnt=%0d want 0", cnt);
    end
    #1;
    reset = 1'b1;
    step();
    step();
    n_tests++;
    if (cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_stay0 cnt=%0d want 0", cnt);
    end
    en = 1;
    step();
    n_tests++;
    if (cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL first_count cnt=%0d want 1", cnt);
    end
  endtask

  task automatic test_wrap16();
    pulse_reset();
    en = 1;
    for (int i = 0; i < 15; i++) step();
    n_tests++;
    if (cnt !== 4'd15 || tc !== 1'b1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL at_max cnt=%0d tc=%b wrap=%b want 15 1 0",
               cnt, tc, wrap);
    end
    en = 0;
    #1;
    n_tests++;
    if (tc !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_no_en tc=%b want 0", tc);
    end
    en = 1;
    #1;
    step();
    n_tests++;
    if (cnt !== 4'd0 || wrap !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap16 cnt=%0d wrap=%b tc=%b want 0 1 0",
               cnt, wrap, tc);
    end
    step();
    n_tests++;
    if (cnt !== 4'd1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_1cyc cnt=%0d wrap=%b want 1 0", cnt, wrap);
    end
  endtask

  task automatic test_max9();
    pulse_reset();
    en9 = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      n_tests++;
      if (cnt9 !== 4'(i)) begin
        n_fail++;
        $display("FAIL max9_seq cnt=%0d want %0d", cnt9, i);
      end
    end
    n_tests++;
    if (tc9 !== 1'b1 || wrap9 !== 1'b0) begin
      n_fail++;
      $display("FAIL max9_tc tc=%b wrap=%b want 1 0", tc9, wrap9);
    end
    step();
    n_tests++;
    if (cnt9 !== 4'd0 || wrap9 !== 1'b1 || tc9 !== 1'b0) begin
      n_fail++;
      $display("FAIL max9_wrap cnt=%0d wrap=%b tc=%b want 0 1 0",
               cnt9, wrap9, tc9);
    end
    step();
    n_tests++;
    if (cnt9 !== 4'd1 || wrap9 !== 1'b0) begin
      n_fail++;
      $display("FAIL max9_after cnt=%0d wrap=%b want 1 0",
               cnt9, wrap9);
    end
    en9 = 0;
  endtask

  task automatic test_clear();
    pulse_reset();
    en = 1;
    for (int i = 0; i < 7; i++) step();
    clr = 1;
    step();
    clr = 0;
    n_tests++;
    if (cnt !== 4'd0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL clear7 cnt=%0d wrap=%b want 0 0", cnt, wrap);
    end
    for (int i = 0; i < 15; i++) step();
    clr = 1;
    step();
    clr = 0;
    n_tests++;
    if (cnt !== 4'd0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_max cnt=%0d wrap=%b want 0 0", cnt, wrap);
    end
    en = 0;
  endtask

`ifdef SYNC_UP_COUNTER_LOAD_EN
  task automatic test_load();
    pulse_reset();
    lv = 4'd12; ld = 1;
    step();
    ld = 0;
    n_tests++;
    if (cnt !== 4'd12 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load12 cnt=%0d wrap=%b want 12 0", cnt, wrap);
    end
    lv = 4'd5; ld = 1; en = 1;
    step();
    ld = 0; en = 0;
    n_tests++;
    if (cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL load_en cnt=%0d want 5", cnt);
    end
    lv = 4'd9; ld = 1; clr = 1;
    step();
    ld = 0; clr = 0;
    n_tests++;
    if (cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_ld cnt=%0d want 0", cnt);
    end
    lv9 = 4'd12; ld9 = 1;
    step();
    ld9 = 0;
    n_tests++;
    if (cnt9 !== 4'd9 || tc9 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp cnt=%0d tc=%b want 9 0", cnt9, tc9);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    en = 0; clr = 0; ld = 0; lv = 4'd0;
    en9 = 0; clr9 = 0; ld9 = 0; lv9 = 4'd0;
    test_reset();
    test_count();
    test_async_reset();
    test_wrap16();
    test_max9();
    test_clear();
`ifdef SYNC_UP_COUNTER_LOAD_EN
    test_load();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
